serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// serial_subtractor_pkg : shared state encoding and default width
// Revision: 1.0
// ============================================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// full_subtractor : 1-bit combinational A - B - Bin cell
// Revision: 1.0
// ============================================================================
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor : bit-serial A - B - Bin, LSB first, start/ready/done
// Revision: 1.0
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] d_msb;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bit_d;
  logic             bit_br;
  logic             last_bit;

  full_subtractor u_cell (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (br),
    .D    (bit_d),
    .Bout (bit_br)
  );

  assign last_bit = (cnt == LAST);

  // New result bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = bit_d;
    res_next         = (res >> 1) | d_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      Diff <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh <= A;
            b_sh <= B;
            br   <= Bin;
            cnt  <= '0;
            res  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= bit_br;
          res  <= res_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            Diff <= res_next;
            Bout <= bit_br;
          end
        end
        default: ;
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor : bench for serial_subtractor at WIDTH 1, 4 and 8
// Revision: 1.0
// ============================================================================
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4, start8;
  logic       a1, b1, bin1, bin4, bin8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       diff1;
  logic       ready1, ready4, ready8;
  logic       done1, done4, done8;
  logic       bout1, bout4, bout8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [8:0] q1[$];
  logic [8:0] q4[$];
  logic [8:0] q8[$];

  typedef struct {
    int a;
    int b;
    int bin;
    int diff;
    int bout;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .Start(start1), .A(a1), .B(b1), .Bin(bin1),
    .Ready(ready1), .Done(done1), .Diff(diff1), .Bout(bout1)
  );
  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .Start(start4), .A(a4), .B(b4), .Bin(bin4),
    .Ready(ready4), .Done(done4), .Diff(diff4), .Bout(bout4)
  );
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .Start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Ready(ready8), .Done(done8), .Diff(diff8), .Bout(bout8)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: {bout, diff} with diff in the low w bits
  function automatic logic [8:0] model(input int w, input int a, input int b, input int bin);
    int         d;
    logic [8:0] r;
    d      = a - b - bin;
    r      = '0;
    r[7:0] = 8'(d & ((1 << w) - 1));
    r[8]   = (d < 0);
    return r;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 1) ? ready1 : (w == 4) ? ready4 : ready8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 1) ? done1 : (w == 4) ? done4 : done8;
  endfunction

  task automatic drive(input int w, input logic s, input int a, input int b, input int bin);
    case (w)
      1:       begin start1 = s; a1 = a[0];    b1 = b[0];    bin1 = bin[0]; end
      4:       begin start4 = s; a4 = 4'(a);   b4 = 4'(b);   bin4 = bin[0]; end
      default: begin start8 = s; a8 = 8'(a);   b8 = 8'(b);   bin8 = bin[0]; end
    endcase
  endtask

  task automatic push_exp(input int w, input logic [8:0] e);
    case (w)
      1:       q1.push_back(e);
      4:       q4.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic wait_ready(input int w);
    int n;
    n = 0;
    while (!get_ready(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(w)) begin
      total_cnt++;
      $display("FAIL ready_timeout w%0d: Ready=0, expected 1", w);
    end
  endtask

  // One operation: launch, expect Done after w+1 cycles, Ready the cycle after
  task automatic run_op(input int w, input int a, input int b, input int bin, input logic [8:0] e);
    int n;
    wait_ready(w);
    drive(w, 1'b1, a, b, bin);
    @(posedge clk);
    push_exp(w, e);
    #1 drive(w, 1'b0, $urandom, $urandom, $urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_done(w) && n < 3 * w + 10);
    check($sformatf("latency_w%0d", w), n, w + 1);
    @(negedge clk);
    check($sformatf("ready_after_w%0d", w), get_ready(w), 1);
    check($sformatf("done_pulse_w%0d", w), get_done(w), 0);
  endtask

  // Scoreboard: every Done pops the oldest expected result
  always @(negedge clk) begin
    if (done4) begin
      check("ready_done_excl_w4", ready4, 0);
      if (q4.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_w4: Done with nothing pending (Diff=%0d Bout=%0d)", diff4, bout4);
      end else check("sb_w4", {bout4, 4'b0, diff4}, q4.pop_front());
    end
    if (done1) begin
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_w1: Done with nothing pending (Diff=%0d Bout=%0d)", diff1, bout1);
      end else check("sb_w1", {bout1, 7'b0, diff1}, q1.pop_front());
    end
    if (done8) begin
      if (q8.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_w8: Done with nothing pending (Diff=%0d Bout=%0d)", diff8, bout8);
      end else check("sb_w8", {bout8, diff8}, q8.pop_front());
    end
  end

  initial begin
    int n;
    int prev;
    int off;
    int k;

    tbl[0] = '{9, 4, 0, 5, 0};
    tbl[1] = '{3, 5, 0, 14, 1};
    tbl[2] = '{0, 0, 1, 15, 1};
    tbl[3] = '{15, 15, 0, 0, 0};
    tbl[4] = '{7, 2, 0, 5, 0};
    tbl[5] = '{0, 15, 1, 0, 1};
    tbl[6] = '{15, 0, 1, 14, 0};

    rst = 1'b1;
    drive(1, 1'b0, 0, 0, 0);
    drive(4, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_ready", ready4, 1);
    check("rst_done", done4, 0);
    check("rst_diff", diff4, 0);
    check("rst_bout", bout4, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", ready4, 1);

    for (int i = 0; i < 7; i++)
      run_op(4, tbl[i].a, tbl[i].b, tbl[i].bin, {tbl[i].bout[0], 4'b0, tbl[i].diff[3:0]});

    // Start pulses and operand churn while busy are ignored; Diff holds
    run_op(4, 9, 4, 0, model(4, 9, 4, 0));
    wait_ready(4);
    drive(4, 1'b1, 3, 5, 0);
    @(posedge clk);
    q4.push_back(model(4, 3, 5, 0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done4) begin
        check("diff_hold_run", diff4, 5);
        check("bout_hold_run", bout4, 0);
        drive(4, n[0], $urandom, $urandom, $urandom);
      end
    end while (!done4 && n < 20);
    drive(4, 1'b1, 1, 1, 0);
    @(negedge clk);
    check("ready_after_ignored", ready4, 1);
    check("diff_held_idle", diff4, 14);
    drive(4, 1'b0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("no_queued_start", q4.size(), 0);

    // Asynchronous reset in the middle of RUN
    wait_ready(4);
    drive(4, 1'b1, 9, 4, 0);
    @(posedge clk);
    #1 drive(4, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", ready4, 1);
    check("midrst_done", done4, 0);
    check("midrst_diff", diff4, 0);
    check("midrst_bout", bout4, 0);
    #1 rst = 1'b0;
    q4.delete();
    @(negedge clk);
    check("midrst_idle", ready4, 1);
    run_op(4, 7, 2, 0, model(4, 7, 2, 0));

    // Start held high with fresh operands every cycle
    prev = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      int ra, rb, rbin;
      ra   = $urandom_range(0, 15);
      rb   = $urandom_range(0, 15);
      rbin = $urandom_range(0, 1);
      drive(4, 1'b1, ra, rb, rbin);
      if (ready4) begin
        q4.push_back(model(4, ra, rb, rbin));
        if (prev >= 0) check("b2b_interval", cyc - prev, 6);
        prev = cyc;
      end
      @(negedge clk);
    end
    drive(4, 1'b0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("b2b_drain", q4.size(), 0);

    // Full operand space at WIDTH=4, visited in a scrambled order
    off = $urandom_range(0, 511);
    for (int i = 0; i < 512; i++) begin
      k = (i * 197 + off) % 512;
      run_op(4, k & 15, (k >> 4) & 15, (k >> 8) & 1, model(4, k & 15, (k >> 4) & 15, (k >> 8) & 1));
    end

    for (int i = 0; i < 8; i++)
      run_op(1, i & 1, (i >> 1) & 1, (i >> 2) & 1, model(1, i & 1, (i >> 1) & 1, (i >> 2) & 1));

    run_op(8, 0, 0, 0, model(8, 0, 0, 0));
    run_op(8, 255, 255, 1, model(8, 255, 255, 1));
    run_op(8, 0, 255, 0, model(8, 0, 255, 0));
    run_op(8, 255, 0, 1, model(8, 255, 0, 1));
    for (int i = 0; i < 150; i++) begin
      int ra, rb, rbin;
      ra   = $urandom_range(0, 255);
      rb   = $urandom_range(0, 255);
      rbin = $urandom_range(0, 1);
      run_op(8, ra, rb, rbin, model(8, ra, rb, rbin));
    end

    repeat (4) @(negedge clk);
    check("final_q1_empty", q1.size(), 0);
    check("final_q4_empty", q4.size(), 0);
    check("final_q8_empty", q8.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
